// File: rtl/aw_resp_scheduler.sv
// ---------------------------------------------------------------------------
// aw_resp_scheduler
//
// Round-robin arbiter that shares one slave AW channel among Masters_Num
// masters. It grants one master at a time and holds that grant until the
// slave accepts the address. Each accepted address pushes the granted master
// ID into the write-response tracking queue. New grants wait while that
// queue is full or while Max_Outstanding writes are still unanswered.
//
// Ports
//   ACLK, ARESET    clock (rising edge) and asynchronous active-high reset
//   M_AWVALID[N]    per-master AW request
//   M_AWREADY[N]    per-master AW accept (only the granted bit can be high)
//   S_AWVALID       AW valid toward the slave
//   S_AWREADY       slave AW ready
//   Sel_Master_ID   granted master, drives the AW payload mux select
//   Queue_Push      one-cycle push strobe to the response queue
//   Queue_Is_Full   response queue full
//   Resp_Done       one write response completed (B handshake)
//   Outstanding     accepted-but-unresponded write count
//   Busy            high while an address is being offered to the slave
// ---------------------------------------------------------------------------
module aw_resp_scheduler #(
  parameter int Masters_Num     = 2,
  parameter int ID_Size         = $clog2(Masters_Num),
  parameter int Max_Outstanding = 4
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic [Masters_Num-1:0] M_AWVALID,
  output logic [Masters_Num-1:0] M_AWREADY,
  output logic                   S_AWVALID,
  input  logic                   S_AWREADY,
  output logic [ID_Size-1:0]     Sel_Master_ID,
  output logic                   Queue_Push,
  input  logic                   Queue_Is_Full,
  input  logic                   Resp_Done,
  output logic [3:0]             Outstanding,
  output logic                   Busy
);

  typedef enum logic {
    IDLE = 1'b0,
    ADDR = 1'b1
  } state_t;

  localparam logic [3:0]         MaxOut = 4'(Max_Outstanding);
  localparam logic [ID_Size-1:0] LastId = ID_Size'(Masters_Num - 1);
  localparam logic [ID_Size:0]   NumW   = (ID_Size + 1)'(Masters_Num);

  state_t               state_q, state_d;
  logic                 s_awvalid_q, s_awvalid_d;
  logic                 busy_q, busy_d;
  logic [ID_Size-1:0]   sel_q, sel_d;
  logic [ID_Size-1:0]   rr_ptr_q, rr_ptr_d;
  logic [3:0]           outstanding_q, outstanding_d;

  logic                 grant_found;
  logic [ID_Size-1:0]   grant_id;
  logic                 grant_go;
  logic                 push;
  logic                 resp_dec;
  logic [2*Masters_Num-1:0] dbl_req;
  logic [ID_Size:0]     cand;

  // Rotate the request vector so bit 0 is the master at rr_ptr; the first
  // set bit then gives the round-robin winner, its ID recovered modulo N.
  always_comb begin
    dbl_req     = {M_AWVALID, M_AWVALID} >> rr_ptr_q;
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int k = 0; k < Masters_Num; k++) begin
      if (!grant_found && dbl_req[k]) begin
        grant_found = 1'b1;
        cand        = {1'b0, rr_ptr_q} + (ID_Size + 1)'(k);
        if (cand >= NumW) begin
          cand = cand - NumW;
        end
        grant_id = cand[ID_Size-1:0];
      end
    end
  end

  // Fullness and the outstanding limit only gate the decision to grant;
  // once in ADDR the grant is never withdrawn.
  assign grant_go = (state_q == IDLE) && grant_found && !Queue_Is_Full &&
                    (outstanding_q < MaxOut);

  assign push     = s_awvalid_q & S_AWREADY;
  assign resp_dec = Resp_Done && (outstanding_q != 4'd0);

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (grant_go) begin
          state_d = ADDR;
          sel_d   = grant_id;
        end
      end
      ADDR: begin
        if (S_AWREADY) begin
          state_d  = IDLE;
          rr_ptr_d = (sel_q == LastId) ? '0 : sel_q + ID_Size'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    s_awvalid_d = (state_d == ADDR);
    busy_d      = (state_d == ADDR);
  end

  // A push and a completion in the same cycle cancel out; a completion with
  // nothing outstanding is dropped.
  always_comb begin
    outstanding_d = outstanding_q;
    case ({push, resp_dec})
      2'b10:   outstanding_d = outstanding_q + 4'd1;
      2'b01:   outstanding_d = outstanding_q - 4'd1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q       <= IDLE;
      s_awvalid_q   <= 1'b0;
      busy_q        <= 1'b0;
      sel_q         <= '0;
      rr_ptr_q      <= '0;
      outstanding_q <= 4'd0;
    end else begin
      state_q       <= state_d;
      s_awvalid_q   <= s_awvalid_d;
      busy_q        <= busy_d;
      sel_q         <= sel_d;
      rr_ptr_q      <= rr_ptr_d;
      outstanding_q <= outstanding_d;
    end
  end

  always_comb begin
    M_AWREADY = '0;
    for (int i = 0; i < Masters_Num; i++) begin
      M_AWREADY[i] = s_awvalid_q && S_AWREADY && (sel_q == ID_Size'(i));
    end
  end

  assign S_AWVALID     = s_awvalid_q;
  assign Queue_Push    = push;
  assign Sel_Master_ID = sel_q;
  assign Outstanding   = outstanding_q;
  assign Busy          = busy_q;

endmodule

// File: tb/tb_aw_resp_scheduler.sv
// ---------------------------------------------------------------------------
// Testbench for aw_resp_scheduler: a table of per-cycle vectors from reset,
// hand-written sequences for the multi-cycle corner cases, and a randomized
// run compared against a behavioural model of the arbiter and counter.
// ---------------------------------------------------------------------------
module tb_aw_resp_scheduler;

  localparam int N    = 2;
  localparam int IDW  = 1;
  localparam int MAXO = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   m_awvalid;
  logic [N-1:0]   m_awready;
  logic           s_awvalid;
  logic           s_awready;
  logic [IDW-1:0] sel_id;
  logic           q_push;
  logic           q_full;
  logic           resp_done;
  logic [3:0]     outstanding;
  logic           busy;

  int errors = 0;
  int checks = 0;

  aw_resp_scheduler #(
    .Masters_Num    (N),
    .ID_Size        (IDW),
    .Max_Outstanding(MAXO)
  ) dut (
    .ACLK         (clk),
    .ARESET       (rst),
    .M_AWVALID    (m_awvalid),
    .M_AWREADY    (m_awready),
    .S_AWVALID    (s_awvalid),
    .S_AWREADY    (s_awready),
    .Sel_Master_ID(sel_id),
    .Queue_Push   (q_push),
    .Queue_Is_Full(q_full),
    .Resp_Done    (resp_done),
    .Outstanding  (outstanding),
    .Busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    int awv;
    int rdy;
    int full;
    int resp;
    int sv;
    int mr;
    int sel;
    int push;
    int out;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model state
  int pend;   // granted master awaiting slave ready, -1 when none
  int m_sel;
  int m_ptr;
  int m_out;

  int pc;

  initial begin
    m_awvalid = '0;
    s_awready = 1'b0;
    q_full    = 1'b0;
    resp_done = 1'b0;
    rst       = 1'b1;
    tick();
    tick();
    chk("rst_svalid", 32'(s_awvalid), 32'd0);
    chk("rst_mready", 32'(m_awready), 32'd0);
    chk("rst_push", 32'(q_push), 32'd0);
    chk("rst_sel", 32'(sel_id), 32'd0);
    chk("rst_out", 32'(outstanding), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // ---- table: single grant then alternating round-robin ----
    vecs[0]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 1, 0, 0, 1, 1, 0, 1, 0};
    vecs[2]  = '{3, 1, 0, 1, 0, 0, 0, 0, 1};
    vecs[3]  = '{3, 1, 0, 0, 1, 2, 1, 1, 0};
    vecs[4]  = '{3, 1, 0, 1, 0, 0, 1, 0, 1};
    vecs[5]  = '{3, 1, 0, 0, 1, 1, 0, 1, 0};
    vecs[6]  = '{3, 1, 0, 1, 0, 0, 0, 0, 1};
    vecs[7]  = '{3, 1, 0, 0, 1, 2, 1, 1, 0};
    vecs[8]  = '{0, 0, 0, 1, 0, 0, 1, 0, 1};
    vecs[9]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
    vecs[10] = '{0, 0, 0, 1, 0, 0, 1, 0, 0};
    vecs[11] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
    pc = 0;
    for (int r = 0; r < 12; r++) begin
      m_awvalid = 2'(vecs[r].awv);
      s_awready = 1'(vecs[r].rdy);
      q_full    = 1'(vecs[r].full);
      resp_done = 1'(vecs[r].resp);
      #1;
      chk($sformatf("tbl%0d_svalid", r), 32'(s_awvalid), 32'(vecs[r].sv));
      chk($sformatf("tbl%0d_mready", r), 32'(m_awready), 32'(vecs[r].mr));
      chk($sformatf("tbl%0d_sel", r), 32'(sel_id), 32'(vecs[r].sel));
      chk($sformatf("tbl%0d_push", r), 32'(q_push), 32'(vecs[r].push));
      chk($sformatf("tbl%0d_out", r), 32'(outstanding), 32'(vecs[r].out));
      chk($sformatf("tbl%0d_busy", r), 32'(busy), 32'(vecs[r].sv));
      if (q_push) pc++;
      tick();
    end
    chk("tbl_push_count", 32'(pc), 32'd4);
    resp_done = 1'b0;

    // ---- held grant on master 1 with slave stalling ----
    pc = 0;
    m_awvalid = 2'b10;
    s_awready = 1'b0;
    #1;
    chk("stall_pre_svalid", 32'(s_awvalid), 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_svalid", 32'(s_awvalid), 32'd1);
      chk("stall_sel", 32'(sel_id), 32'd1);
      chk("stall_mready", 32'(m_awready), 32'd0);
      if (q_push) pc++;
      tick();
    end
    s_awready = 1'b1;
    #1;
    chk("stall_rdy_mready", 32'(m_awready), 32'd2);
    chk("stall_rdy_sel", 32'(sel_id), 32'd1);
    if (q_push) pc++;
    tick();
    m_awvalid = 2'b00;
    s_awready = 1'b0;
    #1;
    chk("stall_post_svalid", 32'(s_awvalid), 32'd0);
    chk("stall_push_count", 32'(pc), 32'd1);
    chk("stall_out", 32'(outstanding), 32'd1);
    resp_done = 1'b1;
    tick();
    resp_done = 1'b0;

    // ---- queue full blocks the grant ----
    m_awvalid = 2'b01;
    s_awready = 1'b1;
    q_full    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("full_svalid", 32'(s_awvalid), 32'd0);
      tick();
    end
    q_full = 1'b0;
    #1;
    chk("full_drop_svalid", 32'(s_awvalid), 32'd0);
    tick();
    #1;
    chk("full_grant_svalid", 32'(s_awvalid), 32'd1);
    chk("full_grant_sel", 32'(sel_id), 32'd0);
    chk("full_grant_push", 32'(q_push), 32'd1);
    tick();
    m_awvalid = 2'b00;
    #1;
    chk("full_out", 32'(outstanding), 32'd1);
    resp_done = 1'b1;
    tick();
    resp_done = 1'b0;

    // ---- outstanding limit ----
    m_awvalid = 2'b11;
    s_awready = 1'b1;
    #1;
    chk("lim_start_out", 32'(outstanding), 32'd0);
    pc = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (q_push) pc++;
      chk("lim_out_bound", 32'(outstanding <= 4'(MAXO)), 32'd1);
      tick();
    end
    #1;
    chk("lim_push_count", 32'(pc), 32'd4);
    chk("lim_out", 32'(outstanding), 32'd4);
    chk("lim_svalid", 32'(s_awvalid), 32'd0);
    resp_done = 1'b1;
    tick();
    resp_done = 1'b0;
    #1;
    chk("lim_dec_out", 32'(outstanding), 32'd3);
    chk("lim_dec_svalid", 32'(s_awvalid), 32'd0);
    tick();
    #1;
    chk("lim_regrant_svalid", 32'(s_awvalid), 32'd1);
    chk("lim_regrant_push", 32'(q_push), 32'd1);
    tick();
    #1;
    chk("lim_refull_out", 32'(outstanding), 32'd4);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("lim_hold_svalid", 32'(s_awvalid), 32'd0);
      tick();
    end
    m_awvalid = 2'b00;
    resp_done = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    resp_done = 1'b0;
    #1;
    chk("lim_drain_out", 32'(outstanding), 32'd0);

    // ---- reset in the middle of ADDR ----
    m_awvalid = 2'b01;
    s_awready = 1'b1;
    tick();
    #1;
    chk("rmid_first_sel", 32'(sel_id), 32'd0);
    chk("rmid_first_push", 32'(q_push), 32'd1);
    tick();
    m_awvalid = 2'b10;
    s_awready = 1'b0;
    tick();
    #1;
    chk("rmid_addr_svalid", 32'(s_awvalid), 32'd1);
    chk("rmid_addr_sel", 32'(sel_id), 32'd1);
    chk("rmid_addr_out", 32'(outstanding), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("rmid_svalid", 32'(s_awvalid), 32'd0);
    chk("rmid_out", 32'(outstanding), 32'd0);
    chk("rmid_push", 32'(q_push), 32'd0);
    chk("rmid_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    m_awvalid = 2'b11;
    s_awready = 1'b1;
    #1;
    chk("rmid_after_svalid", 32'(s_awvalid), 32'd0);
    tick();
    #1;
    chk("rmid_after_sel", 32'(sel_id), 32'd0);
    chk("rmid_after_push", 32'(q_push), 32'd1);
    tick();

    // ---- randomized run against the model ----
    m_awvalid = '0;
    s_awready = 1'b0;
    q_full    = 1'b0;
    resp_done = 1'b0;
    rst       = 1'b1;
    tick();
    tick();
    rst   = 1'b0;
    pend  = -1;
    m_sel = 0;
    m_ptr = 0;
    m_out = 0;
    for (int c = 0; c < 3000; c++) begin
      int e_sv;
      int e_push;
      int e_mr;
      int awv;
      awv       = int'($urandom_range(0, 3));
      m_awvalid = 2'(awv);
      s_awready = ($urandom_range(0, 9) < 6);
      q_full    = ($urandom_range(0, 9) < 2);
      resp_done = ($urandom_range(0, 9) < 3);
      #1;
      e_sv   = (pend >= 0) ? 1 : 0;
      e_push = (e_sv == 1 && s_awready) ? 1 : 0;
      e_mr   = (e_push == 1) ? (1 << pend) : 0;
      chk("rnd_svalid", 32'(s_awvalid), 32'(e_sv));
      chk("rnd_busy", 32'(busy), 32'(e_sv));
      chk("rnd_push", 32'(q_push), 32'(e_push));
      chk("rnd_mready", 32'(m_awready), 32'(e_mr));
      chk("rnd_sel", 32'(sel_id), 32'(m_sel));
      chk("rnd_out", 32'(outstanding), 32'(m_out));
      // next-state of the model
      if (pend >= 0) begin
        if (s_awready) begin
          m_ptr = (pend + 1) % N;
          pend  = -1;
        end
      end else if (awv != 0 && !q_full && m_out < MAXO) begin
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (m_ptr + k) % N;
          if (pend < 0 && ((awv >> idx) & 1) == 1) begin
            pend  = idx;
            m_sel = idx;
          end
        end
      end
      if (e_push == 1 && !(resp_done && m_out > 0)) m_out = m_out + 1;
      else if (e_push == 0 && resp_done && m_out > 0) m_out = m_out - 1;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
